// File: rtl/sreg_en_led_pkg.sv
// Shared helpers for the scan-enabled LED register.
package sreg_en_led_pkg;

    // LED drive for one bit: steady when blinking is off, gated by the
    // blink phase when blinking is on.
    function automatic logic led_bit(
        input logic q,
        input logic phase,
        input logic blink_en
    );
        return blink_en ? (q & phase) : q;
    endfunction

endpackage

// File: rtl/sreg_en_led_bit.sv
// One register bit: scan shift has priority over the functional load,
// otherwise the bit holds. Asynchronous active-high reset.
module sreg_en_led_bit #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic scan_en_i,
    input  logic scan_d_i,
    input  logic d_i,
    output logic q_o
);

    logic q_reg;
    logic q_next;

    // Next-state select: scan shift, then functional load, then hold.
    always_comb begin
        q_next = q_reg;
        if (scan_en_i) begin
            q_next = scan_d_i;
        end else if (en_i) begin
            q_next = d_i;
        end
    end

    // State flop; reset takes effect without waiting for a clock edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_reg <= RESET_BIT;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q_o = q_reg;

endmodule

// File: rtl/sreg_en_led.sv
// Scan-enabled parallel-load register with per-bit LED outputs that can
// blink set bits at a rate set by a free-running prescaler.
module sreg_en_led
    import sreg_en_led_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0,
    parameter int               BLINK_DIV_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             scan_en_i,
    input  logic             scan_d_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             blink_en_i,
    output logic [WIDTH-1:0] q_o,
    output logic             scan_q_o,
    output logic [WIDTH-1:0] led_o
);

    logic [WIDTH-1:0]       scan_in;
    logic [BLINK_DIV_W-1:0] blink_cnt_reg;
    logic [BLINK_DIV_W-1:0] blink_cnt_next;
    logic                   phase;

    // Register bits, chained bit 0 -> bit WIDTH-1 through the scan input.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == 0) begin : g_head
                assign scan_in[gi] = scan_d_i;
            end else begin : g_chain
                assign scan_in[gi] = q_o[gi-1];
            end

            sreg_en_led_bit #(
                .RESET_BIT (RESET_VAL[gi])
            ) u_bit (
                .clk_i     (clk_i),
                .rst_i     (rst_i),
                .en_i      (en_i),
                .scan_en_i (scan_en_i),
                .scan_d_i  (scan_in[gi]),
                .d_i       (d_i[gi]),
                .q_o       (q_o[gi])
            );

            // LED output is purely combinational so blink_en_i acts at once.
            assign led_o[gi] = led_bit(q_o[gi], phase, blink_en_i);
        end
    endgenerate

    assign scan_q_o = q_o[WIDTH-1];

    // Prescaler increment; wraps naturally from all-ones to zero.
    always_comb begin
        blink_cnt_next = blink_cnt_reg + BLINK_DIV_W'(1);
    end

    // Free-running prescaler, independent of enables and of blink_en_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            blink_cnt_reg <= '0;
        end else begin
            blink_cnt_reg <= blink_cnt_next;
        end
    end

    // MSB gives a 50% duty phase with period 2^BLINK_DIV_W cycles.
    assign phase = blink_cnt_reg[BLINK_DIV_W-1];

endmodule

// File: tb/tb_sreg_en_led.sv
// Scoreboard bench for sreg_en_led (WIDTH=4, RESET_VAL=0, BLINK_DIV_W=3).
module tb_sreg_en_led;

    localparam int W   = 4;
    localparam int BDW = 3;
    localparam int PER = 1 << BDW;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         scan_en = 1'b0;
    logic         scan_d = 1'b0;
    logic [W-1:0] d = '0;
    logic         blink_en = 1'b0;
    logic [W-1:0] q;
    logic         scan_q;
    logic [W-1:0] led;

    sreg_en_led #(
        .WIDTH       (W),
        .RESET_VAL   (4'b0000),
        .BLINK_DIV_W (BDW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .scan_en_i  (scan_en),
        .scan_d_i   (scan_d),
        .d_i        (d),
        .blink_en_i (blink_en),
        .q_o        (q),
        .scan_q_o   (scan_q),
        .led_o      (led)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        int         q;
        bit         phase;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    // Reference model: register value and cycles since reset release.
    int   m_q = 0;
    int   m_cycles = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: after each edge, compare DUT against the entry for that edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #3;
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                exp_t e;
                int   exp_led;
                e = sb_q.pop_front();
                if (e.cyc < cyc) begin
                    check("stale_entry", e.cyc, cyc);
                end else begin
                    exp_led = blink_en ? (e.phase ? e.q : 0) : e.q;
                    check("q", int'(q), e.q);
                    check("scan_q", int'(scan_q), (e.q >> (W - 1)) & 1);
                    check("led", int'(led), exp_led);
                    $display("cycle %0d: q=%0h scan_q=%0b led=%0h blink=%0b",
                             cyc, q, scan_q, led, blink_en);
                end
            end
        end
    end

    // Apply inputs for the next edge and push the expected result.
    task automatic step(input bit r, input bit se, input bit sd, input bit e,
                        input int dv, input bit b);
        exp_t x;
        @(posedge clk);
        #1;
        rst = r; scan_en = se; scan_d = sd; en = e; d = W'(dv); blink_en = b;
        if (r) begin
            m_q = 0;
            m_cycles = 0;
        end else begin
            if (se)     m_q = ((m_q * 2) + int'(sd)) % (1 << W);
            else if (e) m_q = dv % (1 << W);
            m_cycles++;
        end
        x.cyc   = cyc + 1;
        x.q     = m_q;
        x.phase = ((m_cycles % PER) >= (PER / 2));
        sb_q.push_back(x);
    endtask

    // Assert reset halfway between edges and check its immediate effect.
    task automatic async_reset();
        @(posedge clk);
        #5;
        rst = 1'b1;
        #1;
        check("async_rst_q", int'(q), 0);
        check("async_rst_led", int'(led), 0);
        check("async_rst_scan_q", int'(scan_q), 0);
        sb_q.delete();
        m_q = 0;
        m_cycles = 0;
    endtask

    initial begin
        #2;
        check("reset_q", int'(q), 0);
        check("reset_led", int'(led), 0);
        check("reset_scan_q", int'(scan_q), 0);

        // Reset held with blinking enabled, then released: LEDs dark for
        // the first half period even though the register is loaded with F.
        step(1, 0, 0, 1, 15, 1);
        step(1, 1, 1, 1, 15, 1);
        step(0, 0, 0, 1, 15, 1);
        for (int i = 0; i < 2 * PER; i++) step(0, 0, 0, 0, 0, 1);

        // Load then hold with different data on d.
        async_reset();
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 'hA, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 'h5, 0);

        // Scan shift from reset value with en asserted and d random.
        async_reset();
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, $urandom_range(0, 15), 0);
        step(0, 1, 0, 1, $urandom_range(0, 15), 0);
        step(0, 1, 1, 1, $urandom_range(0, 15), 0);
        step(0, 1, 1, 1, $urandom_range(0, 15), 0);

        // Steady display of 6, then switch blinking on mid-period.
        step(0, 0, 0, 1, 'h6, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 1);

        // Build 9 by scanning, abort with reset mid-cycle, then load 3.
        step(0, 1, 1, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 1, 0, 0, 1);
        async_reset();
        step(1, 1, 1, 1, 0, 1);
        step(0, 0, 0, 1, 'h3, 0);
        step(0, 0, 0, 0, 0, 0);

        // Randomized traffic with occasional mid-cycle resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                async_reset();
                step(1, $urandom_range(0, 1), $urandom_range(0, 1),
                     $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1));
            end
            step(0, ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1));
        end

        repeat (3) @(posedge clk);
        #4;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
